// File: rtl/dff_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dff_mem_arbiter
//  Function : Two-port round-robin arbiter/sequencer in front of a 16x8 DFF
//             RAM. Serialises single-word read/write transactions from
//             requesters A and B onto the RAM pins. Each requester gets a
//             one-cycle ack pulse, and read data is returned with that ack.
//  Options  : DFF_ARB_STATS_EN adds the per-requester saturating grant
//             counters a_cnt / b_cnt.
//  Revision : 1.0  initial release
// ============================================================================
module dff_mem_arbiter #(
  parameter int AW     = 4,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  output logic          mem_ce_n,
  output logic          mem_lr_n,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
`ifdef DFF_ARB_STATS_EN
  ,
  output logic [7:0]    a_cnt,
  output logic [7:0]    b_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_ACK    = 2'd3
  } state_e;

  // Value of the wait counter during the final WAIT cycle
  localparam logic [1:0] LAST_WAIT = 2'((RD_LAT > 0) ? (RD_LAT - 1) : 0);

  state_e          state_q, state_d;
  logic [1:0]      wcnt_q, wcnt_d;
  logic            owner_q;      // 0 = A, 1 = B
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic            prefer_b_q;   // round-robin pointer, 1 = B wins a tie
  logic [DW-1:0]   a_rdata_q;
  logic [DW-1:0]   b_rdata_q;

  logic            grant;
  logic            grant_b;
  logic            capture;
  logic            mem_active;

  // Next-state, grant decision and read-capture strobe
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    grant   = 1'b0;
    grant_b = 1'b0;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ena && (a_req || b_req)) begin
          grant   = 1'b1;
          // B wins when it is alone, or when both ask and the pointer favours B
          grant_b = b_req && (!a_req || prefer_b_q);
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (we_q) begin
          state_d = S_ACK;
        end else if (RD_LAT == 0) begin
          capture = 1'b1;
          state_d = S_ACK;
        end else begin
          wcnt_d  = 2'd0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wcnt_q == LAST_WAIT) begin
          capture = 1'b1;
          state_d = S_ACK;
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register and wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wcnt_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Latch the winning request's fields and advance the round-robin pointer on grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      prefer_b_q <= 1'b0;
    end else if (grant) begin
      owner_q    <= grant_b;
      we_q       <= grant_b ? b_we    : a_we;
      addr_q     <= grant_b ? b_addr  : a_addr;
      wdata_q    <= grant_b ? b_wdata : a_wdata;
      prefer_b_q <= !grant_b;
    end
  end

  // Capture RAM read data into the owning requester's holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else if (capture) begin
      if (owner_q) begin
        b_rdata_q <= mem_rdata;
      end else begin
        a_rdata_q <= mem_rdata;
      end
    end
  end

  // RAM is driven during ACCESS and every WAIT cycle; address/data always track the latched request
  assign mem_active = (state_q == S_ACCESS) || (state_q == S_WAIT);
  assign mem_ce_n   = !mem_active;
  assign mem_lr_n   = mem_active ? !we_q : 1'b1;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;

  assign a_ack   = (state_q == S_ACK) && !owner_q;
  assign b_ack   = (state_q == S_ACK) &&  owner_q;
  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;
  assign busy    = (state_q != S_IDLE);

`ifdef DFF_ARB_STATS_EN
  logic [7:0] a_cnt_q;
  logic [7:0] b_cnt_q;

  // Saturating per-requester grant counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_cnt_q <= 8'd0;
      b_cnt_q <= 8'd0;
    end else if (grant) begin
      if (!grant_b && (a_cnt_q != 8'hFF)) begin
        a_cnt_q <= a_cnt_q + 8'd1;
      end
      if (grant_b && (b_cnt_q != 8'hFF)) begin
        b_cnt_q <= b_cnt_q + 8'd1;
      end
    end
  end

  assign a_cnt = a_cnt_q;
  assign b_cnt = b_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dff_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dff_mem_arbiter
//  Function : Self-checking bench for dff_mem_arbiter. A transaction-level
//             model predicts every output cycle by cycle; directed scenarios
//             pin the model with literal expectations.
//  Options  : DFF_ARB_STATS_EN enables the grant-counter checks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dff_mem_arbiter;

  localparam int AW     = 4;
  localparam int DW     = 8;
  localparam int RD_LAT = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b0;
  logic          a_req = 1'b0, a_we = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_wdata = '0;
  logic          b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_wdata = '0;
  logic          a_ack, b_ack, mem_ce_n, mem_lr_n, busy;
  logic [DW-1:0] a_rdata, b_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
`ifdef DFF_ARB_STATS_EN
  logic [7:0]    a_cnt, b_cnt;
`endif

  dff_mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_ce_n(mem_ce_n), .mem_lr_n(mem_lr_n), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
`ifdef DFF_ARB_STATS_EN
    , .a_cnt(a_cnt), .b_cnt(b_cnt)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Pin-level RAM: one-cycle registered read, noise when not being read
  logic [DW-1:0] ram [16] = '{default: '0};
  logic [DW-1:0] ram_q = '0;
  always @(posedge clk) begin
    if (!mem_ce_n && !mem_lr_n) ram[mem_addr] <= mem_wdata;
    ram_q <= (!mem_ce_n && mem_lr_n) ? ram[mem_addr] : DW'($urandom);
  end
  assign mem_rdata = ram_q;

  // Transaction-level model: a granted transaction lives L cycles after the
  // grant edge (cycle 1 = RAM access, cycle L = ack). L = 2 for writes,
  // 2 + RD_LAT for reads.
  bit            m_active = 0, m_owner = 0, m_we = 0, m_pref_b = 0;
  int            m_age = 0, m_len = 0, m_acnt = 0, m_bcnt = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_ardata = '0, m_brdata = '0;
  logic [DW-1:0] model_mem [16] = '{default: '0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_pref_b = 0; m_addr = '0; m_wdata = '0;
      m_ardata = '0; m_brdata = '0; m_acnt = 0; m_bcnt = 0;
    end else if (m_active) begin
      if (m_we && m_age == 1) model_mem[m_addr] = m_wdata;
      if (!m_we && m_age == m_len - 1) begin
        if (m_owner) m_brdata = model_mem[m_addr];
        else         m_ardata = model_mem[m_addr];
      end
      if (m_age == m_len) m_active = 0;
      else                m_age++;
    end else if (ena && (a_req || b_req)) begin
      m_owner  = (a_req && b_req) ? m_pref_b : b_req;
      m_we     = m_owner ? b_we    : a_we;
      m_addr   = m_owner ? b_addr  : a_addr;
      m_wdata  = m_owner ? b_wdata : a_wdata;
      m_pref_b = !m_owner;
      m_active = 1;
      m_age    = 1;
      m_len    = m_we ? 2 : 2 + RD_LAT;
      if (m_owner) m_bcnt = (m_bcnt < 255) ? m_bcnt + 1 : 255;
      else         m_acnt = (m_acnt < 255) ? m_acnt + 1 : 255;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      bit drive;
      drive = m_active && (m_age < m_len);
      chk("busy",      busy,      m_active);
      chk("mem_ce_n",  mem_ce_n,  !drive);
      chk("mem_lr_n",  mem_lr_n,  drive ? !m_we : 1'b1);
      chk("mem_addr",  mem_addr,  m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("a_ack",     a_ack,     m_active && m_age == m_len && !m_owner);
      chk("b_ack",     b_ack,     m_active && m_age == m_len &&  m_owner);
      chk("a_rdata",   a_rdata,   m_ardata);
      chk("b_rdata",   b_rdata,   m_brdata);
`ifdef DFF_ARB_STATS_EN
      chk("a_cnt",     a_cnt,     m_acnt);
      chk("b_cnt",     b_cnt,     m_bcnt);
`endif
    end
  end

  // Ack monitor: counts and order log (0 = A, 1 = B)
  int a_ack_n = 0, b_ack_n = 0;
  int ack_log [$];
  always @(negedge clk) begin
    if (a_ack) begin a_ack_n++; ack_log.push_back(0); end
    if (b_ack) begin b_ack_n++; ack_log.push_back(1); end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk); #1 rst_n = 1'b0;
    @(negedge clk); #1 rst_n = 1'b1;
    step();
  endtask

  task automatic wait_idle(input string nm);
    int k;
    for (k = 0; k < 30; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (k == 30) chk({nm, "_idle_timeout"}, 1, 0);
    step();
  endtask

  // Single transaction on one side, req held until ack
  task automatic run_single(input bit side, input bit we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wd);
    int k;
    if (side) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wd; end
    else      begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wd; end
    for (k = 0; k < 30; k++) begin
      @(negedge clk);
      if (side ? b_ack : a_ack) break;
    end
    if (k == 30) chk("single_ack_timeout", 1, 0);
    step();
    if (side) b_req = 0; else a_req = 0;
  endtask

  task automatic rand_a();
    a_we = 1'($urandom); a_addr = AW'($urandom); a_wdata = DW'($urandom);
  endtask
  task automatic rand_b();
    b_we = 1'($urandom); b_addr = AW'($urandom); b_wdata = DW'($urandom);
  endtask

  task automatic random_phase(input int n);
    int sa, sb;
    sa = a_ack_n; sb = b_ack_n;
    for (int c = 0; c < n; c++) begin
      step();
      ena = ($urandom_range(0, 7) != 0);
      if (a_ack_n != sa) begin
        sa = a_ack_n;
        if ($urandom_range(0, 1) == 0) a_req = 0; else rand_a();
      end else if (!a_req) begin
        if ($urandom_range(0, 2) == 0) begin a_req = 1; rand_a(); end
      end else begin
        if ($urandom_range(0, 9) == 0) rand_a();
        if ($urandom_range(0, 19) == 0) a_req = 0;
      end
      if (b_ack_n != sb) begin
        sb = b_ack_n;
        if ($urandom_range(0, 1) == 0) b_req = 0; else rand_b();
      end else if (!b_req) begin
        if ($urandom_range(0, 2) == 0) begin b_req = 1; rand_b(); end
      end else begin
        if ($urandom_range(0, 9) == 0) rand_b();
        if ($urandom_range(0, 19) == 0) b_req = 0;
      end
    end
    a_req = 0; b_req = 0; ena = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests %0d fails %0d", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    bit a_done, b_done, alt;
    int k;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ce_n", mem_ce_n, 1);
    chk("rst_lr_n", mem_lr_n, 1);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_ack", {a_ack, b_ack}, 0);
    chk("rst_rdata", {a_rdata, b_rdata}, 0);
    @(negedge clk); #1 rst_n = 1'b1;
    chk_en = 1'b1;
    ena = 1;
    step();

    // A write 0xAA @0: RAM pins in cycle 1, ack in cycle 2
    a_req = 1; a_we = 1; a_addr = 4'd0; a_wdata = 8'hAA;
    @(posedge clk);
    @(negedge clk);
    chk("wr_c1_pins", {mem_ce_n, mem_lr_n, mem_addr, mem_wdata}, {1'b0, 1'b0, 4'd0, 8'hAA});
    chk("wr_c1_ack", a_ack, 0);
    @(negedge clk);
    chk("wr_c2_ack", a_ack, 1);
    step();
    a_req = 0;

    // A read @0: ack in cycle 3 with 0xAA
    a_req = 1; a_we = 0; a_addr = 4'd0;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rd_c2_ack", a_ack, 0);
    @(negedge clk);
    chk("rd_c3_ack", a_ack, 1);
    chk("rd_c3_data", a_rdata, 8'hAA);
    chk("rd_c3_back", b_ack, 0);
    step();
    a_req = 0;

    // Simultaneous writes to @3 after reset: A first, then B; read returns 0x22
    do_reset();
    ack_log.delete();
    a_req = 1; a_we = 1; a_addr = 4'd3; a_wdata = 8'h11;
    b_req = 1; b_we = 1; b_addr = 4'd3; b_wdata = 8'h22;
    a_done = 0; b_done = 0;
    for (k = 0; k < 30 && !(a_done && b_done); k++) begin
      @(negedge clk);
      if (a_ack) a_done = 1;
      if (b_ack) b_done = 1;
      step();
      if (a_done) a_req = 0;
      if (b_done) b_req = 0;
    end
    a_req = 0; b_req = 0;
    chk("contend_acks", {a_done, b_done}, 2'b11);
    chk("contend_count", ack_log.size(), 2);
    if (ack_log.size() == 2) chk("contend_order", {ack_log[0][0], ack_log[1][0]}, 2'b01);
    wait_idle("contend");
    run_single(1'b0, 1'b0, 4'd3, 8'h00);
    chk("contend_rd", a_rdata, 8'h22);

    // Both held continuously: grants alternate, no ack lost
    wait_idle("alt_pre");
    ack_log.delete();
    a_req = 1; b_req = 1; rand_a(); rand_b();
    for (int c = 0; c < 60; c++) begin
      step();
      if (a_ack_n[0] ^ b_ack_n[0]) rand_a(); else rand_b();
    end
    a_req = 0; b_req = 0;
    wait_idle("alt_post");
    alt = 1;
    for (int i = 1; i < ack_log.size(); i++)
      if (ack_log[i] == ack_log[i-1]) alt = 0;
    chk("alt_order", alt, 1);
    chk("alt_enough", ack_log.size() >= 10, 1);

    // Reset asserted during WAIT: bus released, no ack
    a_req = 1; a_we = 0; a_addr = 4'd7;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rstw_ce_n", mem_ce_n, 1);
    chk("rstw_busy", busy, 0);
    chk("rstw_ack", a_ack, 0);
    a_req = 0;
    @(negedge clk); #1 rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("rstw_noack", {a_ack, b_ack}, 0);
    end
    step();
    run_single(1'b1, 1'b1, 4'd9, 8'h5C);
    run_single(1'b0, 1'b0, 4'd9, 8'h00);
    chk("rstw_rd", a_rdata, 8'h5C);

    // ena=0 blocks grants; ena=1 grants at next edge
    wait_idle("ena_pre");
    ena = 0; a_req = 1; a_we = 1; a_addr = 4'd2; a_wdata = 8'h3C;
    repeat (3) begin
      @(negedge clk);
      chk("ena0_busy", busy, 0);
    end
    step();
    ena = 1;
    @(posedge clk);
    @(negedge clk);
    chk("ena1_grant", {busy, mem_ce_n}, 2'b10);
    @(negedge clk);
    chk("ena1_ack", a_ack, 1);
    step();
    a_req = 0;

    // Randomised traffic
    random_phase(2000);
    wait_idle("rand");

`ifdef DFF_ARB_STATS_EN
    // 300 A grants saturate a_cnt
    do_reset();
    a_req = 1; a_we = 1; a_addr = 4'd1; a_wdata = 8'h01;
    for (k = 0; k < 2000 && a_ack_n < 0; k++) step();
    k = a_ack_n;
    for (int c = 0; c < 1500 && (a_ack_n - k) < 300; c++) step();
    a_req = 0;
    wait_idle("stats");
    chk("stats_acks", (a_ack_n - k) >= 300, 1);
    chk("stats_a_cnt", a_cnt, 8'd255);
    chk("stats_b_cnt", b_cnt, 8'd0);
`endif

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
